// File: rtl/cpu_gregs_dbg_arbiter.sv
// cpu_gregs_dbg_arbiter
// Shares the general-register file's rs1 read port and rd write port between
// the core pipeline and a debug access port. The core normally owns both
// ports; a debug request waits for an idle core slot, or forces a short core
// stall once it has waited MAX_WAIT cycles. Debug owns the ports only while
// the core is stalled, so a core write and a debug write never reach the
// register file at the same time.
module cpu_gregs_dbg_arbiter #(
  parameter int XLEN     = 32,
  parameter int IDX_W    = 5,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             reset,

  // core pipeline side
  input  logic             core_idle,
  output logic             core_stall,
  input  logic [IDX_W-1:0] core_rs1_idx,
  input  logic [IDX_W-1:0] core_rs2_idx,
  input  logic             core_rd_wen,
  input  logic [IDX_W-1:0] core_rd_idx,
  input  logic [XLEN-1:0]  core_rd_dat,
  output logic [XLEN-1:0]  core_rs1_dat,
  output logic [XLEN-1:0]  core_rs2_dat,

  // register file side
  output logic [IDX_W-1:0] gr_rs1_idx,
  output logic [IDX_W-1:0] gr_rs2_idx,
  output logic             gr_rd_wen,
  output logic [IDX_W-1:0] gr_rd_idx,
  output logic [XLEN-1:0]  gr_rd_dat,
  input  logic [XLEN-1:0]  gr_rs1_dat,
  input  logic [XLEN-1:0]  gr_rs2_dat,

  // debug request channel
  input  logic             dbg_req_valid,
  output logic             dbg_req_ready,
  input  logic             dbg_req_we,
  input  logic [IDX_W-1:0] dbg_req_idx,
  input  logic [XLEN-1:0]  dbg_req_wdat,

  // debug response channel
  output logic             dbg_rsp_valid,
  input  logic             dbg_rsp_ready,
  output logic [XLEN-1:0]  dbg_rsp_rdat
);

  // Wait counter must hold 0..MAX_WAIT; keep at least one bit so that
  // MAX_WAIT = 0 (stall immediately) still elaborates.
  localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT     = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_CAPT  = 3'd3,
    ST_WR       = 3'd4,
    ST_RESP     = 3'd5
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] wait_cnt_reg;
  logic             req_we_reg;
  logic [IDX_W-1:0] req_idx_reg;
  logic [XLEN-1:0]  req_wdat_reg;
  logic             rsp_valid_reg;
  logic [XLEN-1:0]  rsp_rdat_reg;
  logic             stall_w;
  logic             wait_done_w;

  // Debug owns the register ports only in these three states.
  assign stall_w = (state_reg == ST_RD_ISSUE) ||
                   (state_reg == ST_RD_CAPT)  ||
                   (state_reg == ST_WR);

  // Leave WAIT on a free core slot, or when patience has run out.
  assign wait_done_w = core_idle || (wait_cnt_reg == WAIT_LIMIT);

  assign core_stall    = stall_w;
  assign dbg_req_ready = (state_reg == ST_IDLE) && !reset;
  assign dbg_rsp_valid = rsp_valid_reg;
  assign dbg_rsp_rdat  = rsp_rdat_reg;

  // Read data always flows straight back; the core ignores it while stalled.
  assign core_rs1_dat = gr_rs1_dat;
  assign core_rs2_dat = gr_rs2_dat;

  // Debug access sequencer: accept, wait for a slot, access, respond.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      wait_cnt_reg  <= '0;
      req_we_reg    <= 1'b0;
      req_idx_reg   <= '0;
      req_wdat_reg  <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdat_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (dbg_req_valid && dbg_req_ready) begin
            req_we_reg   <= dbg_req_we;
            req_idx_reg  <= dbg_req_idx;
            req_wdat_reg <= dbg_req_wdat;
            wait_cnt_reg <= '0;
            state_reg    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_done_w) begin
            state_reg <= req_we_reg ? ST_WR : ST_RD_ISSUE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
          end
        end
        ST_RD_ISSUE: begin
          // Index presented this cycle; registered read returns it next cycle.
          state_reg <= ST_RD_CAPT;
        end
        ST_RD_CAPT: begin
          // x0 reads as zero regardless of what the file returns.
          rsp_rdat_reg  <= (req_idx_reg == '0) ? '0 : gr_rs1_dat;
          rsp_valid_reg <= 1'b1;
          state_reg     <= ST_RESP;
        end
        ST_WR: begin
          rsp_rdat_reg  <= '0;
          rsp_valid_reg <= 1'b1;
          state_reg     <= ST_RESP;
        end
        ST_RESP: begin
          // Valid and data stay frozen until the consumer takes them.
          if (dbg_rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Port steering: core by default, debug index/data during its stall slots.
  always_comb begin
    gr_rs1_idx = core_rs1_idx;
    gr_rs2_idx = core_rs2_idx;
    gr_rd_wen  = core_rd_wen && !stall_w;
    gr_rd_idx  = core_rd_idx;
    gr_rd_dat  = core_rd_dat;
    case (state_reg)
      ST_RD_ISSUE: begin
        gr_rs1_idx = req_idx_reg;
      end
      ST_WR: begin
        gr_rd_wen = 1'b1;
        gr_rd_idx = req_idx_reg;
        gr_rd_dat = req_wdat_reg;
      end
      default: begin
      end
    endcase
  end

endmodule
